// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: RV32I funct3 width
// codes, FSM state encoding and the illegal-funct3 decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Width codes with no RV32I meaning, or unsigned widths used on a store.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = is_store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling for the load/store master (combinational):
// extracts and extends load lanes, merges SB/SH data into the read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the memory word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = 8'd0;
        endcase
        if (addr_lo[1]) begin
            half_sel = word[31:16];
        end else begin
            half_sel = word[15:0];
        end
    end

    // Sign- or zero-extend the selected lane according to the load width.
    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    // Merge store data into the read word; SW takes the full store word.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_LB: begin
                case (addr_lo)
                    2'd0:    store_word = {word[31:8], wdata[7:0]};
                    2'd1:    store_word = {word[31:16], wdata[7:0], word[7:0]};
                    2'd2:    store_word = {word[31:24], wdata[7:0], word[15:0]};
                    2'd3:    store_word = {wdata[7:0], word[23:0]};
                    default: store_word = word;
                endcase
            end
            F3_LH: begin
                if (addr_lo[1]) begin
                    store_word = {wdata[15:0], word[15:0]};
                end else begin
                    store_word = {word[31:16], wdata[15:0]};
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-only data memory.
// One request at a time: IDLE -> (RD) -> (WR) -> RESP -> IDLE.
// Macro LSU_ALIGN_CHECK_EN: when defined, misaligned H/W accesses and
// addresses >= MEM_BYTES are rejected with resp_err; when undefined the
// address is forced to natural alignment and range is not checked.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_re_data
);

    lsu_state_t        state, state_next;
    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] req_addr_eff;

    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = req_valid && (state == IDLE);

    // Classify the incoming request and derive the address actually used.
    always_comb begin
        req_err      = f3_illegal(req_funct3, req_is_store);
        req_addr_eff = req_addr;
`ifdef LSU_ALIGN_CHECK_EN
        if (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && req_addr[0]) begin
            req_err = 1'b1;
        end else if ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end else if (req_addr >= ADDR_W'(MEM_BYTES)) begin
            req_err = 1'b1;
        end else begin
            req_err = req_err;
        end
`else
        case (req_funct3)
            F3_LH, F3_LHU: req_addr_eff = {req_addr[ADDR_W-1:1], 1'b0};
            F3_LW:         req_addr_eff = {req_addr[ADDR_W-1:2], 2'b00};
            default:       req_addr_eff = req_addr;
        endcase
`endif
    end

    // State register; reset drops straight back to IDLE, aborting any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!accept) begin
                    state_next = IDLE;
                end else if (req_err) begin
                    state_next = RESP;
                end else if (req_is_store && (req_funct3 == F3_LW)) begin
                    state_next = WR;
                end else begin
                    state_next = RD;
                end
            end
            RD: begin
                if (is_store_q) begin
                    state_next = WR;
                end else begin
                    state_next = RESP;
                end
            end
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request on accept; capture load data or merged word in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            word_q     <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr_eff;
            word_q     <= req_wdata;
            rdata_q    <= 32'd0;
            err_q      <= req_err;
        end else if (state == RD) begin
            if (is_store_q) begin
                word_q <= store_word;
            end else begin
                rdata_q <= load_data;
            end
        end else begin
            rdata_q <= rdata_q;
        end
    end

    lsu_lane_align u_lane_align (
        .word       (mem_re_data),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (word_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Outputs decoded from state so they fall together with an async reset.
    always_comb begin
        req_ready    = (state == IDLE);
        mem_r_enable = (state == RD);
        mem_w_enable = (state == WR);
        resp_valid   = (state == RESP);
        if ((state == RD) || (state == WR)) begin
            mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        end else begin
            mem_address = '0;
        end
        if (state == WR) begin
            mem_wr_data = word_q;
        end else begin
            mem_wr_data = 32'd0;
        end
        if (state == RESP) begin
            resp_rdata = rdata_q;
            resp_err   = err_q;
        end else begin
            resp_rdata = 32'd0;
            resp_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a 128-byte word memory
// model (combinational read, synchronous write). Expectations follow the
// LSU_ALIGN_CHECK_EN setting shared with the design build.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_re_data;

    logic [31:0] mem [0:31];

    int compared   = 0;
    int mismatched = 0;

    lsu_mem_master #(.ADDR_W(32), .MEM_BYTES(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_address  (mem_address),
        .mem_wr_data  (mem_wr_data),
        .mem_re_data  (mem_re_data)
    );

    always #5 clk = ~clk;

    assign mem_re_data = mem[mem_address[6:2]];

    always @(posedge clk) begin
        if (mem_w_enable) mem[mem_address[6:2]] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and check latency, enables, address and response.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input int exp_r, input int exp_w,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic [31:0] exp_wr);
        int          cyc;
        int          rcnt;
        int          wcnt;
        int          both;
        logic [31:0] wr_seen;
        logic [31:0] addr_seen;
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid = 1'b0;
        cyc = 1; rcnt = 0; wcnt = 0; both = 0; wr_seen = 32'd0; addr_seen = 32'd0;
        while (!resp_valid && cyc < 12) begin
            if (mem_r_enable) begin rcnt++; addr_seen = mem_address; end
            if (mem_w_enable) begin wcnt++; wr_seen = mem_wr_data; addr_seen = mem_address; end
            if (mem_r_enable && mem_w_enable) both++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " rd_cycles"}, rcnt, exp_r);
        check({tag, " wr_cycles"}, wcnt, exp_w);
        check({tag, " rd_and_wr"}, both, 32'd0);
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
        if (exp_r + exp_w > 0) check({tag, " mem_addr"}, addr_seen, {addr[31:2], 2'b00});
        if (exp_w > 0) check({tag, " wr_data"}, wr_seen, exp_wr);
        tick();
        check({tag, " pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " rdata_idle"}, resp_rdata, 32'd0);
    endtask

    logic [2:0]  b2b_f3   [3];
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0] = 32'h0102_0304;
        mem[1] = 32'h8899_AABB;
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset state
        #3;
        check("rst ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst err", {31'd0, resp_err}, 32'd0);
        check("rst enables", {30'd0, mem_r_enable, mem_w_enable}, 32'd0);
        check("rst mem_addr", mem_address, 32'd0);
        check("rst wr_data", mem_wr_data, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Loads with lane extraction
        run_req("LW 4",  1'b0, 3'b010, 32'h4, 32'd0, 2, 1, 0, 32'h8899_AABB, 1'b0, 32'd0);
        run_req("LB 5",  1'b0, 3'b000, 32'h5, 32'd0, 2, 1, 0, 32'hFFFF_FFAA, 1'b0, 32'd0);
        run_req("LBU 5", 1'b0, 3'b100, 32'h5, 32'd0, 2, 1, 0, 32'h0000_00AA, 1'b0, 32'd0);
        run_req("LH 6",  1'b0, 3'b001, 32'h6, 32'd0, 2, 1, 0, 32'hFFFF_8899, 1'b0, 32'd0);
        run_req("LHU 6", 1'b0, 3'b101, 32'h6, 32'd0, 2, 1, 0, 32'h0000_8899, 1'b0, 32'd0);

        // Alignment and range
`ifdef LSU_ALIGN_CHECK_EN
        run_req("LW 6",    1'b0, 3'b010, 32'h6,  32'd0, 1, 0, 0, 32'd0, 1'b1, 32'd0);
        run_req("LW 0x80", 1'b0, 3'b010, 32'h80, 32'd0, 1, 0, 0, 32'd0, 1'b1, 32'd0);
        run_req("LH 5",    1'b0, 3'b001, 32'h5,  32'd0, 1, 0, 0, 32'd0, 1'b1, 32'd0);
`else
        run_req("LW 6",    1'b0, 3'b010, 32'h6,  32'd0, 2, 1, 0, 32'h8899_AABB, 1'b0, 32'd0);
        run_req("LW 0x80", 1'b0, 3'b010, 32'h80, 32'd0, 2, 1, 0, 32'h0102_0304, 1'b0, 32'd0);
        run_req("LH 5",    1'b0, 3'b001, 32'h5,  32'd0, 2, 1, 0, 32'hFFFF_AABB, 1'b0, 32'd0);
`endif

        // Stores
        run_req("SB 6",  1'b1, 3'b000, 32'h6, 32'hFFFF_FF11, 3, 1, 1, 32'd0, 1'b0, 32'h8811_AABB);
        run_req("LW 4 after SB", 1'b0, 3'b010, 32'h4, 32'd0, 2, 1, 0, 32'h8811_AABB, 1'b0, 32'd0);
        run_req("SW 8",  1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 2, 0, 1, 32'd0, 1'b0, 32'hDEAD_BEEF);
        run_req("LW 8",  1'b0, 3'b010, 32'h8, 32'd0, 2, 1, 0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        run_req("SH 0xA", 1'b1, 3'b001, 32'hA, 32'h0000_CAFE, 3, 1, 1, 32'd0, 1'b0, 32'hCAFE_BEEF);
        run_req("SBU err", 1'b1, 3'b100, 32'h8, 32'h55, 1, 0, 0, 32'd0, 1'b1, 32'd0);
        run_req("LW 8 after err", 1'b0, 3'b010, 32'h8, 32'd0, 2, 1, 0, 32'hCAFE_BEEF, 1'b0, 32'd0);

        // Reset during the write cycle of SH 0x4
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h4; req_wdata = 32'h1234;
        tick();
        req_valid = 1'b0;
        check("abort rd", {31'd0, mem_r_enable}, 32'd1);
        tick();
        check("abort in wr", {31'd0, mem_w_enable}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort w_enable drop", {31'd0, mem_w_enable}, 32'd0);
        check("abort ready in rst", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("abort ready", {31'd0, req_ready}, 32'd1);
        check("abort no resp", {31'd0, resp_valid}, 32'd0);
        tick();
        check("abort no resp later", {31'd0, resp_valid}, 32'd0);
        run_req("LW 4 after abort", 1'b0, 3'b010, 32'h4, 32'd0, 2, 1, 0, 32'h8811_AABB, 1'b0, 32'd0);

        // Back-to-back loads with req_valid held high
        b2b_f3[0] = 3'b010; b2b_addr[0] = 32'h4; b2b_exp[0] = 32'h8811_AABB;
        b2b_f3[1] = 3'b100; b2b_addr[1] = 32'h7; b2b_exp[1] = 32'h0000_0088;
        b2b_f3[2] = 3'b001; b2b_addr[2] = 32'h4; b2b_exp[2] = 32'hFFFF_AABB;
        req_valid = 1'b1; req_is_store = 1'b0;
        req_funct3 = b2b_f3[0]; req_addr = b2b_addr[0];
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b%0d ready idle", i), {31'd0, req_ready}, 32'd1);
            tick();
            check($sformatf("b2b%0d ready rd", i), {31'd0, req_ready}, 32'd0);
            if (i < 2) begin
                req_funct3 = b2b_f3[i+1]; req_addr = b2b_addr[i+1];
            end else begin
                req_valid = 1'b0;
            end
            tick();
            check($sformatf("b2b%0d resp_valid", i), {31'd0, resp_valid}, 32'd1);
            check($sformatf("b2b%0d ready resp", i), {31'd0, req_ready}, 32'd0);
            check($sformatf("b2b%0d rdata", i), resp_rdata, b2b_exp[i]);
            tick();
        end
        run_req("funct3 011", 1'b0, 3'b011, 32'h4, 32'd0, 1, 0, 0, 32'd0, 1'b1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
